// File: rtl/multi_result_buf.sv
// First-word-fall-through result buffer behind the shift-add multiplier pipeline.
// It never stalls the pipeline; when full it drops the incoming product and sets a sticky overflow flag.
// Optional: define MULTI_DROP_CNT_EN to add the saturating 8-bit drop_cnt output.
module multi_result_buf #(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [M+N-1:0]             in_prod,
    input  logic                       in_vld,
    output logic [M+N-1:0]             out_data,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    input  logic                       clr_ovf
`ifdef MULTI_DROP_CNT_EN
    ,
    output logic [7:0]                 drop_cnt
`endif
);

    localparam int W  = M + N;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A pop frees a slot in the same edge, so a full buffer can still accept
    // a word while it is being drained.
    assign w_pop  = !w_empty & out_rdy;
    assign w_push = in_vld & (!w_full | w_pop);
    assign w_drop = in_vld & w_full & !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= in_prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Set has priority so a drop in the clearing cycle is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef MULTI_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign out_data = r_mem[r_rd_ptr];
    assign out_vld  = !w_empty;
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_multi_result_buf.sv
// Scoreboard bench for multi_result_buf: accepted products are queued by the
// stimulus, and a negedge monitor compares every popped head entry in order.
module tb_multi_result_buf;

    localparam int M     = 4;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int W     = M + N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] in_prod = '0;
    logic         in_vld = 1'b0;
    logic [W-1:0] out_data;
    logic         out_vld;
    logic         out_rdy = 1'b0;
    logic         full;
    logic         empty;
    logic [2:0]   count;
    logic         ovf;
    logic         clr_ovf = 1'b0;
`ifdef MULTI_DROP_CNT_EN
    logic [7:0]   drop_cnt;
`endif

    logic [W-1:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    multi_result_buf #(.M(M), .N(N), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_prod  (in_prod),
        .in_vld   (in_vld),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ovf      (ovf),
        .clr_ovf  (clr_ovf)
`ifdef MULTI_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] d);
        exp_q.push_back(d);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_data"}, 32'(out_data), 32'h0);
        chk({tag, "_out_vld"},  32'(out_vld),  32'h0);
        chk({tag, "_full"},     32'(full),     32'h0);
        chk({tag, "_empty"},    32'(empty),    32'h1);
        chk({tag, "_count"},    32'(count),    32'h0);
        chk({tag, "_ovf"},      32'(ovf),      32'h0);
`ifdef MULTI_DROP_CNT_EN
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'h0);
`endif
    endtask

    // Monitor: a pop happens at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_unexpected: got %0h expected no output", out_data);
            end else begin
                chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset mid-cycle, outputs settle without a clock edge
        #1 rst_n = 1'b0;
        #1 chk_reset("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        out_rdy = 1'b1;
        repeat (3) cyc();
        chk("idle_count", 32'(count), 32'h0);
        chk("idle_empty", 32'(empty), 32'h1);
        out_rdy = 1'b0;

        // 2: single product
        in_prod = 8'h0F; in_vld = 1'b1; push_exp(8'h0F);
        cyc();
        in_vld = 1'b0;
        chk("single_vld", 32'(out_vld), 32'h1);
        chk("single_data", 32'(out_data), 32'h0F);
        chk("single_count", 32'(count), 32'h1);
        out_rdy = 1'b1;
        cyc();
        out_rdy = 1'b0;
        chk("single_empty", 32'(empty), 32'h1);

        // 3: overflow
        for (int i = 1; i <= 5; i++) begin
            in_prod = W'(i); in_vld = 1'b1;
            if (i <= 4) push_exp(W'(i));
            cyc();
            if (i == 4) begin
                chk("ovf_full", 32'(full), 32'h1);
                chk("ovf_pre", 32'(ovf), 32'h0);
            end
        end
        in_vld = 1'b0;
        chk("ovf_set", 32'(ovf), 32'h1);
        chk("ovf_count", 32'(count), 32'h4);
`ifdef MULTI_DROP_CNT_EN
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'h1);
`endif
        out_rdy = 1'b1;
        repeat (4) cyc();
        out_rdy = 1'b0;
        chk("ovf_drained", 32'(empty), 32'h1);
        chk("ovf_sticky", 32'(ovf), 32'h1);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'h0);

        // 4: full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) begin
            in_prod = W'(i); in_vld = 1'b1; push_exp(W'(i));
            cyc();
        end
        in_prod = 8'h06; in_vld = 1'b1; out_rdy = 1'b1; push_exp(8'h06);
        cyc();
        in_vld = 1'b0; out_rdy = 1'b0;
        chk("pp_count", 32'(count), 32'h4);
        chk("pp_ovf", 32'(ovf), 32'h0);
        chk("pp_head", 32'(out_data), 32'h02);
`ifdef MULTI_DROP_CNT_EN
        chk("pp_drop_cnt", 32'(drop_cnt), 32'h1);
`endif
        out_rdy = 1'b1;
        repeat (4) cyc();
        out_rdy = 1'b0;
        chk("pp_empty", 32'(empty), 32'h1);

        // 5: wraparound, words on even cycles, ready toggling every cycle
        for (int i = 0; i < 24; i++) begin
            out_rdy = (i % 2 == 0);
            in_vld  = (i % 2 == 0);
            in_prod = W'(8'h10 + i / 2);
            if (i % 2 == 0) push_exp(W'(8'h10 + i / 2));
            cyc();
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        repeat (3) cyc();
        out_rdy = 1'b0;
        chk("wrap_empty", 32'(empty), 32'h1);
        chk("wrap_ovf", 32'(ovf), 32'h0);
        chk("wrap_sb", 32'(exp_q.size()), 32'h0);

        // 6: set wins over clear, then reset with entries held
        for (int i = 1; i <= 5; i++) begin
            in_prod = W'(8'h20 + i); in_vld = 1'b1;
            if (i <= 4) push_exp(W'(8'h20 + i));
            cyc();
        end
        chk("prio_pre", 32'(ovf), 32'h1);
        in_prod = 8'h26; in_vld = 1'b1; clr_ovf = 1'b1;
        cyc();
        in_vld = 1'b0; clr_ovf = 1'b0;
        chk("prio_ovf", 32'(ovf), 32'h1);
`ifdef MULTI_DROP_CNT_EN
        chk("prio_drop_cnt", 32'(drop_cnt), 32'h3);
`endif
        out_rdy = 1'b1;
        cyc();
        out_rdy = 1'b0;
        chk("prio_count3", 32'(count), 32'h3);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_busy");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_empty", 32'(empty), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_result_buf.md
# multi_result_buf

Result buffer that sits directly downstream of the last `multi_cell` stage of the pipelined shift-add multiplier. It captures each finished product, marked by the last stage's `rdy`, into a small first-word-fall-through FIFO and presents it to the consumer over a valid/ready handshake. The multiplier pipeline cannot stall, so the buffer never back-pressures it. When the buffer is full, it drops incoming products and records the overflow.

## Interface
- `M`, default 4: multiplicand width, matching the pipeline.
- `N`, default 4: multiplier width, matching the pipeline; W = M+N.
- `DEPTH`, default 4: number of entries; must be a power of two and at least 2.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset; asynchronous, active-low. Single clock domain.
- `in_prod`, input, W: product from the last stage's `multi_acco`.
- `in_vld`, input, 1: product valid; connect to the last stage's `rdy`.
- `out_data`, output, W: head entry; meaningful only while `out_vld`=1.
- `out_vld`, output, 1: buffer non-empty.
- `out_rdy`, input, 1: consumer accepts the head entry.
- `full`, output, 1: count == DEPTH.
- `empty`, output, 1: count == 0.
- `count`, output, $clog2(DEPTH)+1: current number of stored entries.
- `ovf`, output, 1: sticky flag; set when a product has been dropped.
- `clr_ovf`, input, 1: synchronous clear of `ovf`.
- `drop_cnt`, output, 8: number of dropped products. Present only with `MULTI_DROP_CNT_EN`.

## Operation
- `pop` = `out_vld` & `out_rdy`. `out_rdy` is ignored while the buffer is empty.
- `push` = `in_vld` & (!`full` | `pop`).
  - When full and popping in the same cycle, the push is accepted.
- `drop` = `in_vld` & `full` & !`pop`. The word is discarded and storage is unchanged.
- Storage is a DEPTH×W register array.
- `wr_ptr` and `rd_ptr` are log2(DEPTH)-bit pointers that wrap modulo DEPTH. Full and empty are derived from `count`, not from pointer equality.
- `count` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together, or on neither.
- `out_data` = mem[`rd_ptr`], driven combinationally from the registered array (first-word fall-through).
- `ovf`:
  - Set on `drop`.
  - Cleared when `clr_ovf`=1 and there is no drop that cycle.
  - Set wins over clear.
- Products are stored unmodified at W bits; no arithmetic is performed.
- Reset while operating discards all stored entries immediately.
  - Products still in flight in the pipeline are not buffered until `rst_n` deasserts.
- Reset values:
  - `out_data`=0, `out_vld`=0, `full`=0, `empty`=1, `count`=0, `ovf`=0.
  - Both pointers are 0 and all memory words are 0.
  - `drop_cnt`=0 when present.

## Timing
- Latency, push to output: a product pushed at edge k into an empty buffer gives `out_vld`=1 and `out_data`=product in the cycle after edge k.
- Pop: the entry leaves at the edge where `pop`=1. The next entry, if any, is visible in the following cycle.
- `full`, `empty`, `count` and `ovf` are registered and reflect the edge just taken.
- Sustained throughput: one push and one pop per cycle with no bubbles.
- The pipeline can present `in_vld`=1 every cycle. When full, the buffer accepts a new word only in a cycle where it also pops.

## Configuration
- `MULTI_DROP_CNT_EN` defined:
  - Adds the `drop_cnt` port, an 8-bit counter.
  - Increments on each `drop` and saturates at 255.
  - Cleared only by reset; `clr_ovf` does not affect it.
- `MULTI_DROP_CNT_EN` undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use M=N=4, DEPTH=4.
1. Reset and idle. Assert `rst_n`=0 mid-cycle, then release. Required: all outputs at their reset values with no clock edge needed; `out_rdy`=1 while empty leaves `count`=0.
2. Single product. Push 0x0F with `out_rdy`=0. Required: next cycle `out_vld`=1, `out_data`=0x0F, `count`=1. Then raise `out_rdy` for 1 cycle. Required: `empty`=1 after that edge.
3. Overflow. Push 0x01 to 0x05 on consecutive cycles with `out_rdy`=0. Required:
   - `full`=1 after the 4th push.
   - 0x05 is dropped and `ovf`=1; `drop_cnt`=1 if the macro is enabled.
   - Draining yields 0x01, 0x02, 0x03, 0x04.
   - `clr_ovf` then clears `ovf`.
4. Full with simultaneous push and pop. With the buffer full of 0x01 to 0x04, push 0x06 while `out_rdy`=1. Required: `count` stays 4, `ovf` stays 0, and the drain order is 0x02, 0x03, 0x04, 0x06.
5. Wraparound. Stream 0x10 to 0x1B (12 words) with `out_rdy` toggling every cycle. Required: output sequence exactly 0x10 to 0x1B in order, no drops, and the pointers wrap at least twice.
6. Set/clear priority and reset. With `ovf` already set, assert `clr_ovf` in the same cycle as a new drop. Required: `ovf` remains 1. Then assert `rst_n`=0 with `count`=3. Required: everything returns to reset values immediately.
